mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM stage of the MIPS32 pipeline; consumes the EX stage outputs (IR_ex, NPC_ex, ALU_res, B_ex, cond) through the EX/MEM pipeline register.
- Performs word load/store against data memory over a req/ack handshake and resolves branches.
- Presents registered results to WB and stalls EX via ready_ex while a memory access is outstanding.

Parameters:
- TIMEOUT, 15: max cycles waiting for dmem_ack before abort.
- TW, 4: timeout counter width; must satisfy TIMEOUT < 2**TW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_ex  in  1  EX outputs valid this cycle.
- ready_ex  out  1  MEM accepts EX outputs; combinational, =1 only in IDLE.
- IR_ex  in  32  instruction; opcode = IR_ex[31:26].
- NPC_ex  in  32  next PC.
- ALU_res  in  32  ALU result: effective address (LW/SW), branch target (BEQZ/BNEQZ).
- B_ex  in  32  store data.
- cond  in  1  1 when A==0.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  byte address, word aligned.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  memory completion; 1-cycle pulse.
- dmem_rdata  in  32  load data; valid with dmem_ack.
- valid_mem  out  1  MEM outputs valid; 1-cycle pulse per instruction.
- IR_mem, NPC_mem, ALU_mem  out  32 each  registered copies.
- LMD  out  32  load memory data.
- branch_taken  out  1  pulse coincident with valid_mem.
- branch_pc  out  32  branch target, = ALU_mem.
- halted  out  1  sticky after HLT.
- err  out  1  sticky: misaligned access or ack timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output register = 0 (valid_mem, IR_mem, NPC_mem, ALU_mem, LMD, branch_taken, dmem_req/we/addr/wdata, halted, err); timeout counter = 0.
- Opcodes:
  - RR: 000000–000101; RI: 010000–010101.
  - LW 110000; SW 110001.
  - BNEQZ 110100, taken when cond==0.
  - BEQZ 110101, taken when cond==1.
  - HLT 111111.
  - Any other opcode is a NOP: pass-through, no access, no branch.
- States: IDLE, WAIT, HALTED.
- IDLE, handshake: transfer occurs on a rising edge with valid_ex && ready_ex; IR, NPC, ALU and B are latched.
  - RR/RI/NOP/branch: next cycle valid_mem=1 with the latched values; branch_taken per the cond rule. Latency 1.
  - LW/SW with ALU_res[1:0]!=0: no access; err set; valid_mem next cycle; LMD=0.
  - LW/SW aligned: next cycle dmem_req=1, dmem_we=(SW), dmem_addr=ALU_res, dmem_wdata=B_ex; go to WAIT; counter cleared.
  - HLT: valid_mem next cycle; halted=1; go to HALTED.
- WAIT: ready_ex=0; dmem_req/we/addr/wdata held stable.
  - On the edge sampling dmem_ack=1: dmem_req=0; for LW, LMD<=dmem_rdata (SW leaves LMD unchanged); valid_mem=1 next cycle; go to IDLE.
  - Minimum load latency is 2 cycles (accept -> req -> ack -> valid_mem).
  - Counter increments each WAIT cycle without ack. When it reaches TIMEOUT: dmem_req=0, err=1, LMD=0 (LW), valid_mem=1, go to IDLE.
  - Ack on the same edge the counter reaches TIMEOUT counts as success.
- HALTED: ready_ex=0, dmem_req=0, no further valid_mem. Exit only via reset.
- dmem_ack while not in WAIT is ignored.
- valid_mem and branch_taken drop after one cycle unless another instruction completes.
- Back-to-back: an ALU op accepted on the cycle after valid_mem gives consecutive valid_mem pulses. A new instruction is accepted on the cycle after a WAIT completion (IDLE).
- Reset asserted during WAIT: dmem_req drops immediately (async); the pending access is abandoned.
- err and halted clear only on reset.

Test Plan:
- Reset, then RR IR_ex=0x04000000, ALU_res=0x00000002, valid_ex -> next cycle valid_mem=1, ALU_mem=0x2, branch_taken=0, dmem_req never asserted.
- LW IR_ex=0xC0000000, ALU_res=0x00000010; ack after 3 cycles with rdata=0xDEADBEEF -> ready_ex=0 during WAIT, dmem_addr=0x10, dmem_we=0; LMD=0xDEADBEEF, valid_mem one cycle after ack.
- SW IR_ex=0xC4000000, ALU_res=0x20, B_ex=0x00000005, immediate ack -> dmem_we=1, wdata=0x5; valid_mem; LMD unchanged; err=0.
- BEQZ 0xD4000000 with cond=1, ALU_res=0x108 -> branch_taken=1, branch_pc=0x108. BNEQZ 0xD0000000 with cond=1 -> branch_taken=0. BNEQZ with cond=0 -> branch_taken=1.
- LW with ALU_res=0x13 -> no dmem_req, err=1, valid_mem next cycle. Separate run, LW with ack never returned -> after 15 WAIT cycles dmem_req=0, err=1, LMD=0, valid_mem=1.
- HLT 0xFC000000 -> halted=1, ready_ex stuck at 0. Then rst_n low during a pending LW -> dmem_req=0 immediately, all outputs 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// MEM stage bus bundle: EX-side handshake, data memory port and WB-side results.
// master = the MEM stage itself, slave = its environment (EX, memory, WB).
interface mem_stage_if;
  logic        valid_ex;
  logic        ready_ex;
  logic [31:0] IR_ex;
  logic [31:0] NPC_ex;
  logic [31:0] ALU_res;
  logic [31:0] B_ex;
  logic        cond;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        valid_mem;
  logic [31:0] IR_mem;
  logic [31:0] NPC_mem;
  logic [31:0] ALU_mem;
  logic [31:0] LMD;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        halted;
  logic        err;

  modport master (
    input  valid_ex, IR_ex, NPC_ex, ALU_res, B_ex, cond, dmem_ack, dmem_rdata,
    output ready_ex, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           valid_mem, IR_mem, NPC_mem, ALU_mem, LMD, branch_taken, branch_pc,
           halted, err
  );

  modport slave (
    output valid_ex, IR_ex, NPC_ex, ALU_res, B_ex, cond, dmem_ack, dmem_rdata,
    input  ready_ex, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           valid_mem, IR_mem, NPC_mem, ALU_mem, LMD, branch_taken, branch_pc,
           halted, err
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: word load/store over a req/ack data memory port,
// branch resolution, and registered results toward WB.
//
// state  | meaning
// IDLE   | ready for the next EX instruction
// WAIT   | memory access outstanding, waiting for dmem_ack or timeout
// HALTED | HLT retired; frozen until reset
module mem_stage #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input logic         clk,
  input logic         rst_n,
  mem_stage_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [5:0] OP_LW    = 6'b110000;
  localparam logic [5:0] OP_SW    = 6'b110001;
  localparam logic [5:0] OP_BNEQZ = 6'b110100;
  localparam logic [5:0] OP_BEQZ  = 6'b110101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Abort fires on the edge where the count of ack-less WAIT cycles hits TIMEOUT.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic          dmem_req, dmem_we;
  logic [31:0]   dmem_addr, dmem_wdata;
  logic          valid_mem, branch_taken, halted, err;
  logic [31:0]   ir_mem, npc_mem, alu_mem, lmd;

  logic [5:0] op;
  logic       is_mem, is_sw, is_hlt, misaligned, take_branch, pending_lw;

  // Decode of the instruction offered by EX and of the one held for the access.
  always_comb begin
    op          = bus.IR_ex[31:26];
    is_sw       = (op == OP_SW);
    is_mem      = (op == OP_LW) || is_sw;
    is_hlt      = (op == OP_HLT);
    misaligned  = (bus.ALU_res[1:0] != 2'b00);
    take_branch = ((op == OP_BNEQZ) && !bus.cond) || ((op == OP_BEQZ) && bus.cond);
    pending_lw  = (ir_mem[31:26] == OP_LW);
  end

  // Pipeline register, memory port and sequencing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      valid_mem    <= 1'b0;
      branch_taken <= 1'b0;
      halted       <= 1'b0;
      err          <= 1'b0;
      ir_mem       <= '0;
      npc_mem      <= '0;
      alu_mem      <= '0;
      lmd          <= '0;
    end else begin
      valid_mem    <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.valid_ex) begin
            ir_mem  <= bus.IR_ex;
            npc_mem <= bus.NPC_ex;
            alu_mem <= bus.ALU_res;
            if (is_mem && misaligned) begin
              err       <= 1'b1;
              lmd       <= '0;
              valid_mem <= 1'b1;
            end else if (is_mem) begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_sw;
              dmem_addr  <= bus.ALU_res;
              dmem_wdata <= bus.B_ex;
              cnt        <= '0;
              state      <= S_WAIT;
            end else if (is_hlt) begin
              halted    <= 1'b1;
              valid_mem <= 1'b1;
              state     <= S_HALTED;
            end else begin
              valid_mem    <= 1'b1;
              branch_taken <= take_branch;
            end
          end
        end
        S_WAIT: begin
          // Ack wins over a timeout landing on the same edge.
          if (bus.dmem_ack) begin
            dmem_req  <= 1'b0;
            valid_mem <= 1'b1;
            if (pending_lw) lmd <= bus.dmem_rdata;
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            dmem_req  <= 1'b0;
            err       <= 1'b1;
            valid_mem <= 1'b1;
            if (pending_lw) lmd <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HALTED: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs toward EX, memory and WB.
  always_comb begin
    bus.ready_ex     = (state == S_IDLE);
    bus.dmem_req     = dmem_req;
    bus.dmem_we      = dmem_we;
    bus.dmem_addr    = dmem_addr;
    bus.dmem_wdata   = dmem_wdata;
    bus.valid_mem    = valid_mem;
    bus.IR_mem       = ir_mem;
    bus.NPC_mem      = npc_mem;
    bus.ALU_mem      = alu_mem;
    bus.LMD          = lmd;
    bus.branch_taken = branch_taken;
    bus.branch_pc    = alu_mem;
    bus.halted       = halted;
    bus.err          = err;
  end

endmodule
